// File: rtl/logic_engine_bridge.sv
// Bridge between a level-held CPU request/ack port and a ready/valid logic engine.
// One transaction is in flight at a time; a hung engine is aborted after TIMEOUT_CYCLES.
module logic_engine_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [31:0] ERR_DATA       = 32'hDEAD0001
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        logic_req,
   input  logic [31:0] logic_addr,
   output logic        logic_ack,
   output logic [31:0] logic_data,
   output logic        eng_req_valid,
   input  logic        eng_req_ready,
   output logic [31:0] eng_req_addr,
   input  logic        eng_rsp_valid,
   output logic        eng_rsp_ready,
   input  logic [31:0] eng_rsp_data,
   input  logic        eng_rsp_err,
   input  logic        err_clr,
   output logic        busy,
   output logic        timeout_err,
   output logic        rsp_err,
   output logic        stale_drop,
   output logic [15:0] req_count
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RSP, ACK, DRAIN} state_t;

   // Last WAIT_RSP cycle index: the abort fires after TIMEOUT_CYCLES cycles in WAIT_RSP.
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   state_t      state_nxt;
   logic [15:0] to_cnt;
   logic        rsp_ready_st;
   logic        rsp_take;
   logic        to_hit;
   logic        stale_take;
   logic        latch_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      logic_ack     = 1'b0;
      eng_req_valid = 1'b0;
      rsp_ready_st  = 1'b0;
      rsp_take      = 1'b0;
      to_hit        = 1'b0;
      stale_take    = 1'b0;
      latch_addr    = 1'b0;
      busy          = (state != IDLE);
      case (state)
         IDLE: begin
            rsp_ready_st = 1'b1;
            stale_take   = eng_rsp_valid;
            if (logic_req) begin
               latch_addr = 1'b1;
               state_nxt  = ISSUE;
            end
         end
         ISSUE: begin
            eng_req_valid = 1'b1;
            if (eng_req_ready) state_nxt = WAIT_RSP;
         end
         WAIT_RSP: begin
            rsp_ready_st = 1'b1;
            // A response arriving on the final counted cycle beats the timeout.
            if (eng_rsp_valid) begin
               rsp_take  = 1'b1;
               state_nxt = ACK;
            end else if (to_cnt == TO_LAST) begin
               to_hit    = 1'b1;
               state_nxt = ACK;
            end
         end
         ACK: begin
            logic_ack = 1'b1;
            state_nxt = DRAIN;
         end
         DRAIN: begin
            rsp_ready_st = 1'b1;
            stale_take   = eng_rsp_valid;
            if (!logic_req) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Ready must read low while reset is held, even though IDLE normally accepts.
   assign eng_rsp_ready = rsp_ready_st & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_req_addr <= '0;
         logic_data   <= '0;
         to_cnt       <= '0;
         timeout_err  <= 1'b0;
         rsp_err      <= 1'b0;
         stale_drop   <= 1'b0;
         req_count    <= '0;
      end else begin
         if (latch_addr) eng_req_addr <= logic_addr;

         if (rsp_take)    logic_data <= eng_rsp_data;
         else if (to_hit) logic_data <= ERR_DATA;

         if (state == ISSUE)         to_cnt <= '0;
         else if (state == WAIT_RSP) to_cnt <= to_cnt + 16'd1;

         timeout_err <= to_hit                   | (timeout_err & ~err_clr);
         rsp_err     <= (rsp_take & eng_rsp_err) | (rsp_err     & ~err_clr);
         stale_drop  <= stale_take               | (stale_drop  & ~err_clr);

         if (logic_ack) req_count <= req_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_logic_engine_bridge.sv
// Scoreboard bench for logic_engine_bridge: expected ack data is queued when a
// transaction is driven and popped by the ack monitor.
module tb_logic_engine_bridge;

   localparam int          TO  = 8;
   localparam logic [31:0] ERR = 32'hDEAD0001;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        logic_req;
   logic [31:0] logic_addr;
   logic        logic_ack;
   logic [31:0] logic_data;
   logic        eng_req_valid;
   logic        eng_req_ready;
   logic [31:0] eng_req_addr;
   logic        eng_rsp_valid;
   logic        eng_rsp_ready;
   logic [31:0] eng_rsp_data;
   logic        eng_rsp_err;
   logic        err_clr;
   logic        busy;
   logic        timeout_err;
   logic        rsp_err;
   logic        stale_drop;
   logic [15:0] req_count;

   logic_engine_bridge #(.TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) dut (
      .clk(clk), .rst_n(rst_n), .logic_req(logic_req), .logic_addr(logic_addr),
      .logic_ack(logic_ack), .logic_data(logic_data),
      .eng_req_valid(eng_req_valid), .eng_req_ready(eng_req_ready), .eng_req_addr(eng_req_addr),
      .eng_rsp_valid(eng_rsp_valid), .eng_rsp_ready(eng_rsp_ready),
      .eng_rsp_data(eng_rsp_data), .eng_rsp_err(eng_rsp_err),
      .err_clr(err_clr), .busy(busy), .timeout_err(timeout_err), .rsp_err(rsp_err),
      .stale_drop(stale_drop), .req_count(req_count)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          exp_count = 0;
   int          lat;
   logic        prev_ack = 1'b0;
   logic [31:0] exp_q[$];

   always @(posedge clk) cyc++;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Ack monitor: pops the scoreboard and checks the ack is a single-cycle pulse.
   always @(negedge clk) begin
      if (rst_n && logic_ack) begin
         check_val("ack_pulse", 32'(prev_ack), 32'd0);
         if (exp_q.size() == 0) check_val("unexpected_ack", 32'd1, 32'd0);
         else                   check_val("ack_data", logic_data, exp_q.pop_front());
      end
      prev_ack = logic_ack;
   end

   task automatic txn(input logic [31:0] addr, input logic [31:0] data, input logic err,
                      input int rdy_dly, input int rsp_dly, input bit no_rsp,
                      input int hold, input bit late, output int latency);
      int start;
      int t;
      latency = -1;
      @(negedge clk);
      logic_req     = 1'b1;
      logic_addr    = addr;
      eng_req_ready = (rdy_dly == 0);
      eng_rsp_valid = 1'b0;
      exp_q.push_back(no_rsp ? ERR : data);
      start = cyc;
      for (int i = 0; i <= rdy_dly; i++) begin
         @(negedge clk);
         check_val("req_valid", 32'(eng_req_valid), 32'd1);
         check_val("req_addr", eng_req_addr, addr);
         check_val("issue_rsp_ready", 32'(eng_rsp_ready), 32'd0);
         if (i == rdy_dly) eng_req_ready = 1'b1;
      end
      @(negedge clk);
      check_val("wait_rsp_ready", 32'(eng_rsp_ready), 32'd1);
      check_val("wait_req_valid", 32'(eng_req_valid), 32'd0);
      if (!no_rsp) begin
         repeat (rsp_dly) @(negedge clk);
         eng_rsp_valid = 1'b1;
         eng_rsp_data  = data;
         eng_rsp_err   = err;
         @(negedge clk);
         eng_rsp_valid = 1'b0;
         eng_rsp_err   = 1'b0;
      end
      t = 0;
      while (!logic_ack && t < TO + 20) begin
         @(negedge clk);
         t++;
      end
      if (!logic_ack) check_val("ack_seen", 32'd0, 32'd1);
      else            latency = cyc - start;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_val("no_reissue", 32'(eng_req_valid), 32'd0);
         check_val("drain_busy", 32'(busy), 32'd1);
         eng_rsp_valid = late && (i == 0);
      end
      eng_rsp_valid = 1'b0;
      logic_req     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_val("back_idle", 32'(busy), 32'd0);
      exp_count++;
      check_val("req_count", 32'(req_count), 32'(exp_count));
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst_n         = 1'b0;
      logic_req     = 1'b0;
      logic_addr    = '0;
      eng_req_ready = 1'b0;
      eng_rsp_valid = 1'b0;
      eng_rsp_data  = '0;
      eng_rsp_err   = 1'b0;
      err_clr       = 1'b0;
      #3;
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_rsp_ready", 32'(eng_rsp_ready), 32'd0);
      check_val("rst_data", logic_data, 32'd0);
      check_val("rst_count", 32'(req_count), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Zero-wait engine: ack three cycles after request
      txn(32'h40, 32'hABCD1234, 1'b0, 0, 0, 1'b0, 0, 1'b0, lat);
      check_val("latency_zero_wait", 32'(lat), 32'd3);
      check_val("no_stale", 32'(stale_drop), 32'd0);
      check_val("no_rsp_err", 32'(rsp_err), 32'd0);

      // Engine stalls the request for five cycles
      txn(32'h44, 32'h11112222, 1'b0, 5, 2, 1'b0, 0, 1'b0, lat);
      check_val("stall_no_timeout", 32'(timeout_err), 32'd0);
      check_val("stall_latency", 32'(lat), 32'd10);

      // No response: timeout
      txn(32'h48, 32'h0, 1'b0, 0, 0, 1'b1, 0, 1'b0, lat);
      check_val("timeout_latency", 32'(lat), 32'(TO + 2));
      check_val("timeout_flag", 32'(timeout_err), 32'd1);
      check_val("timeout_data_held", logic_data, ERR);
      pulse_clr();
      check_val("timeout_cleared", 32'(timeout_err), 32'd0);

      // Response on the exact timeout cycle wins, with engine error flag
      txn(32'h4C, 32'h5555AAAA, 1'b1, 0, TO - 1, 1'b0, 0, 1'b0, lat);
      check_val("edge_latency", 32'(lat), 32'(TO + 2));
      check_val("edge_no_timeout", 32'(timeout_err), 32'd0);
      check_val("rsp_err_set", 32'(rsp_err), 32'd1);
      pulse_clr();
      check_val("rsp_err_cleared", 32'(rsp_err), 32'd0);

      // Request held after ack, late response in DRAIN
      txn(32'h50, 32'h0BADF00D, 1'b0, 0, 1, 1'b0, 4, 1'b1, lat);
      check_val("stale_in_drain", 32'(stale_drop), 32'd1);
      pulse_clr();
      check_val("stale_cleared", 32'(stale_drop), 32'd0);

      // Set beats clear in the same cycle
      @(negedge clk);
      err_clr       = 1'b1;
      eng_rsp_valid = 1'b1;
      @(negedge clk);
      err_clr       = 1'b0;
      eng_rsp_valid = 1'b0;
      check_val("set_wins_clear", 32'(stale_drop), 32'd1);
      pulse_clr();

      // Reset in WAIT_RSP aborts the transaction
      @(negedge clk);
      logic_req     = 1'b1;
      logic_addr    = 32'h60;
      eng_req_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_val("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_busy", 32'(busy), 32'd0);
      check_val("arst_ack", 32'(logic_ack), 32'd0);
      check_val("arst_req_valid", 32'(eng_req_valid), 32'd0);
      check_val("arst_rsp_ready", 32'(eng_rsp_ready), 32'd0);
      check_val("arst_addr", eng_req_addr, 32'd0);
      check_val("arst_count", 32'(req_count), 32'd0);
      exp_count = 0;
      logic_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      eng_rsp_valid = 1'b1;
      eng_rsp_data  = 32'h77777777;
      @(negedge clk);
      eng_rsp_valid = 1'b0;
      check_val("post_rst_stale", 32'(stale_drop), 32'd1);
      check_val("post_rst_no_ack", 32'(logic_ack), 32'd0);
      pulse_clr();

      txn(32'h64, 32'hCAFEBABE, 1'b0, 0, 0, 1'b0, 0, 1'b0, lat);
      check_val("post_rst_latency", 32'(lat), 32'd3);

      repeat (2) @(negedge clk);
      check_val("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
